// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ack bus between the fetch stage (master) and imem (slave).
interface fetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, addr, input ack, rdata);
    modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, issues imem word requests, and feeds decode through
// a registered output slot backed by a one-entry skid buffer.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 stall_i,
    input  logic                 redirect_valid_i,
    input  logic [31:0]          redirect_pc_i,
    fetch_stage_if.master        imem,
    output logic [31:0]          ir_o,
    output logic [31:0]          pc_ir_o,
    output logic                 ir_valid_o
);
    typedef enum logic {FETCH, DRAIN} state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] target_pc_q, target_pc_d;
    logic [31:0] ir_q, ir_d, pc_ir_q, pc_ir_d;
    logic        ir_valid_q, ir_valid_d;
    logic [31:0] buf_ir_q, buf_ir_d, buf_pc_q, buf_pc_d;
    logic        buf_valid_q, buf_valid_d;

    logic        req, done, slot_free;
    logic [31:0] redir_pc;
    logic        unused_rpc_lo;

    assign redir_pc      = {redirect_pc_i[31:2], 2'b00};
    assign unused_rpc_lo = ^redirect_pc_i[1:0];

    // A full buffer blocks new requests; DRAIN keeps the stale request alive until acked.
    assign req       = !reset_i && ((state_q == FETCH && !buf_valid_q) || state_q == DRAIN);
    assign done      = req && imem.ack;
    assign slot_free = !ir_valid_q || !stall_i;

    assign imem.req   = req;
    assign imem.addr  = fetch_pc_q;
    assign ir_o       = ir_q;
    assign pc_ir_o    = pc_ir_q;
    assign ir_valid_o = ir_valid_q;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        target_pc_d = target_pc_q;
        ir_d        = ir_q;
        pc_ir_d     = pc_ir_q;
        ir_valid_d  = ir_valid_q;
        buf_ir_d    = buf_ir_q;
        buf_pc_d    = buf_pc_q;
        buf_valid_d = buf_valid_q;

        if (redirect_valid_i) begin
            ir_valid_d  = 1'b0;
            buf_valid_d = 1'b0;
            ir_d        = NOP_WORD;
            if (req && !imem.ack) begin
                state_d     = DRAIN;
                target_pc_d = redir_pc;
            end else begin
                state_d    = FETCH;
                fetch_pc_d = redir_pc;
            end
        end else if (state_q == DRAIN) begin
            if (done) begin
                state_d    = FETCH;
                fetch_pc_d = target_pc_q;
            end
        end else begin
            if (slot_free) begin
                if (buf_valid_q) begin
                    // Older buffered word goes first; a same-cycle arrival takes its place.
                    ir_d        = buf_ir_q;
                    pc_ir_d     = buf_pc_q;
                    ir_valid_d  = 1'b1;
                    buf_valid_d = done;
                    if (done) begin
                        buf_ir_d = imem.rdata;
                        buf_pc_d = fetch_pc_q;
                    end
                end else if (done) begin
                    ir_d       = imem.rdata;
                    pc_ir_d    = fetch_pc_q;
                    ir_valid_d = 1'b1;
                end else begin
                    ir_d       = NOP_WORD;
                    ir_valid_d = 1'b0;
                end
            end else if (done) begin
                buf_ir_d    = imem.rdata;
                buf_pc_d    = fetch_pc_q;
                buf_valid_d = 1'b1;
            end
            if (done) fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= FETCH;
            fetch_pc_q  <= RESET_PC;
            target_pc_q <= RESET_PC;
            ir_q        <= NOP_WORD;
            pc_ir_q     <= 32'h0;
            ir_valid_q  <= 1'b0;
            buf_ir_q    <= NOP_WORD;
            buf_pc_q    <= 32'h0;
            buf_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            target_pc_q <= target_pc_d;
            ir_q        <= ir_d;
            pc_ir_q     <= pc_ir_d;
            ir_valid_q  <= ir_valid_d;
            buf_ir_q    <= buf_ir_d;
            buf_pc_q    <= buf_pc_d;
            buf_valid_q <= buf_valid_d;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: queue-based reference model checked every cycle,
// plus literal expectations at key points.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, stall, redirect_valid, ack;
    logic [31:0] redirect_pc, ir, pc_ir;
    logic        ir_valid;

    always #5 clk = ~clk;

    fetch_stage_if bus();

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return ~a ^ 32'h5A5A_0000;
    endfunction

    assign bus.ack   = ack;
    assign bus.rdata = word_of(bus.addr);

    fetch_stage dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .stall_i          (stall),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .imem             (bus.master),
        .ir_o             (ir),
        .pc_ir_o          (pc_ir),
        .ir_valid_o       (ir_valid)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: words delivered but not yet taken by decode, oldest first.
    typedef struct { logic [31:0] pc; logic [31:0] w; } ent_t;
    ent_t        m_q[$];
    logic [31:0] m_pc, m_target, m_last;
    logic        m_drain;

    int wait_cyc;   // cycles memory waits before acking a request
    int cnt;        // cycles the current request has been pending

    function automatic logic m_req();
        return !reset && (m_drain || m_q.size() < 2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic mreq);
        logic done;
        done = mreq && ack;
        if (reset) begin
            m_q.delete();
            m_pc = 32'h0; m_target = 32'h0; m_last = 32'h0; m_drain = 1'b0;
        end else if (redirect_valid) begin
            m_q.delete();
            if (mreq && !ack) begin
                m_drain = 1'b1; m_target = redirect_pc & ~32'h3;
            end else begin
                m_drain = 1'b0; m_pc = redirect_pc & ~32'h3;
            end
        end else if (m_drain) begin
            if (done) begin m_pc = m_target; m_drain = 1'b0; end
        end else begin
            if (m_q.size() > 0 && !stall) void'(m_q.pop_front());
            if (done) begin
                m_q.push_back('{pc: m_pc, w: word_of(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
        if (m_q.size() > 0) m_last = m_q[0].pc;
    endtask

    task automatic check_all();
        chk("imem_req", {31'b0, bus.req}, {31'b0, m_req()});
        if (m_req()) chk("imem_addr", bus.addr, m_pc);
        chk("ir_valid", {31'b0, ir_valid}, {31'b0, m_q.size() > 0});
        chk("ir", ir, (m_q.size() > 0) ? m_q[0].w : NOP);
        chk("pc_ir", pc_ir, m_last);
    endtask

    // One clock: memory responds per wait_cyc, DUT and model advance, outputs compared.
    task automatic step();
        logic mreq, r;
        r    = bus.req;
        mreq = m_req();
        ack  = r && (cnt >= wait_cyc);
        @(posedge clk);
        model_update(mreq);
        if (reset || (r && ack)) cnt = 0;
        else if (r) cnt++;
        @(negedge clk);
        check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid = 1'b1; redirect_pc = pc;
        step();
        redirect_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        ack = 1'b0; wait_cyc = 0; cnt = 0;
        m_q.delete(); m_pc = 0; m_target = 0; m_last = 0; m_drain = 0;
        @(negedge clk);
        steps(2);
        chk("rst_ir", ir, NOP);
        chk("rst_pc_ir", pc_ir, 32'h0);
        chk("rst_ir_valid", {31'b0, ir_valid}, 32'h0);
        chk("rst_req", {31'b0, bus.req}, 32'h0);

        // Streaming with ack always high.
        reset = 1'b0;
        #1;
        chk("first_req", {31'b0, bus.req}, 32'h1);
        chk("first_addr", bus.addr, 32'h0);
        steps(6);
        chk("stream_pc_ir", pc_ir, 32'd20);
        chk("stream_addr", bus.addr, 32'd24);
        chk("stream_ir", ir, 32'hA5A5_FFEB);

        // Stall three cycles: one word buffered, then request drops.
        stall = 1'b1;
        steps(3);
        chk("stall_req", {31'b0, bus.req}, 32'h0);
        chk("stall_pc_ir", pc_ir, 32'd20);
        stall = 1'b0;
        step();
        chk("release_pc_ir", pc_ir, 32'd24);
        step();
        chk("release_next", pc_ir, 32'd28);
        steps(2);

        // Three-cycle ack latency.
        wait_cyc = 2;
        steps(9);

        // Redirect while a request is outstanding.
        for (int i = 0; i < 10 && !(bus.req && cnt == 0); i++) step();
        redirect(32'h100);
        chk("drain_ir_valid", {31'b0, ir_valid}, 32'h0);
        begin
            int n = 0;
            while (!ir_valid && n < 20) begin step(); n++; end
            if (n >= 20) chk("drain_timeout", 32'h0, 32'h1);
        end
        chk("drain_first_pc", pc_ir, 32'h100);
        steps(3);

        // Redirect with full buffer under stall: no drain.
        wait_cyc = 0;
        steps(3);
        stall = 1'b1;
        steps(2);
        redirect(32'h200);
        chk("bufredir_addr", bus.addr, 32'h200);
        chk("bufredir_req", {31'b0, bus.req}, 32'h1);
        stall = 1'b0;
        steps(3);

        // Redirect coincident with ack while stalled, buffer empty.
        stall = 1'b1;
        redirect(32'h300);
        chk("ackredir_addr", bus.addr, 32'h300);
        chk("ackredir_valid", {31'b0, ir_valid}, 32'h0);
        stall = 1'b0;
        steps(3);

        // Wrap and low-bit masking.
        redirect(32'hFFFF_FFFC);
        chk("wrap_pre", bus.addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_addr", bus.addr, 32'h0);
        redirect(32'h103);
        chk("mask_addr", bus.addr, 32'h100);
        steps(3);

        // Reset in the middle of a drain.
        wait_cyc = 3;
        for (int i = 0; i < 10 && !(bus.req && cnt == 0); i++) step();
        redirect(32'h400);
        reset = 1'b1;
        step();
        chk("mid_rst_valid", {31'b0, ir_valid}, 32'h0);
        chk("mid_rst_pc_ir", pc_ir, 32'h0);
        reset = 1'b0;
        #1;
        chk("mid_rst_addr", bus.addr, 32'h0);
        wait_cyc = 0;
        steps(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage that sits directly upstream of the instruction decoder. It owns the program counter and issues word requests to instruction memory over a req/ack handshake. It presents the fetched instruction word and its PC to decode through a registered output slot with a one-entry skid buffer, so a downstream stall never loses a returned word. Redirects from branch/jump resolution squash all in-flight and buffered instructions.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- NOP_WORD, 32'h0000_0013: word driven on `ir` when no valid instruction is presented (ADDI x0,x0,0).
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  decode cannot accept `ir` this cycle.
- redirect_valid  input  1  one-cycle pulse: restart fetch at `redirect_pc`.
- redirect_pc  input  32  new fetch address; bits [1:0] forced to 0.
- imem_req  output  1  request valid to instruction memory.
- imem_addr  output  32  word address of the request, byte-addressed.
- imem_ack  input  1  memory completes the current request this cycle.
- imem_rdata  input  32  instruction word; valid when `imem_ack`=1.
- ir  output  32  instruction to decoder (registered).
- pc_ir  output  32  PC of `ir` (registered).
- ir_valid  output  1  `ir`/`pc_ir` hold a real instruction.

## Operation
- Internal state: `fetch_pc`, `target_pc`, FSM {FETCH, DRAIN}, output slot (`ir`, `pc_ir`, `ir_valid`), skid buffer (`buf_ir`, `buf_pc`, `buf_valid`).
- Handshake: a request completes on an edge where `imem_req`=1 and `imem_ack`=1. Once raised, `imem_req` and `imem_addr` stay constant until completion. Memory may ack in the first cycle of a request.
- `imem_req` = !reset && ((FETCH && !buf_valid) || DRAIN). `imem_addr` = `fetch_pc`.
- FETCH, request completes, no redirect:
  - `fetch_pc` += 4 (wraps modulo 2^32).
  - Word goes to the output slot if the slot is empty or being consumed (`!ir_valid || !stall`) and the buffer is empty.
  - Otherwise the word goes to the buffer.
- Consume: if `ir_valid` && `!stall`, the slot loads from the buffer if `buf_valid` (buffer clears), else from a completing word, else `ir_valid` goes to 0.
- Ordering: a buffered word always leaves before a newer word. When the buffer drains into the slot in the same cycle a word completes, the new word enters the buffer.
- Redirect (priority over everything):
  - Clears `ir_valid` and `buf_valid`; `ir` becomes NOP_WORD.
  - If a request is outstanding and not completing this cycle: go to DRAIN and set `target_pc` = redirect_pc.
  - Otherwise: stay in FETCH and set `fetch_pc` = redirect_pc. Any word completing in the same cycle is discarded.
- DRAIN: hold `imem_req` at the stale address. On completion, discard the data, set `fetch_pc` = `target_pc`, and go to FETCH. A new redirect during DRAIN overwrites `target_pc` only.
- When `ir_valid`=0, `ir`=NOP_WORD and `pc_ir` holds its last value.

## Timing
- Reset values: FSM=FETCH, `fetch_pc`=RESET_PC, `ir`=NOP_WORD, `pc_ir`=0, `ir_valid`=0, `buf_valid`=0, `imem_req`=0 while reset is high.
- `imem_req`=1 with `imem_addr`=RESET_PC in the first cycle after reset drops.
- Latency: a word acked at edge N appears on `ir` after edge N (visible cycle N+1) when unstalled.
- Throughput: 1 instr/cycle with `imem_ack` held high and `stall` low; `imem_addr` advances by 4 every cycle.
- Stall: `ir`, `pc_ir`, `ir_valid` hold unchanged. At most one further word is accepted into the buffer; then `imem_req` drops until the buffer drains.
- Redirect at edge N: `ir_valid`=0 in cycle N+1.
  - No outstanding request: `imem_addr`=redirect_pc in cycle N+1.
  - Otherwise: redirect_pc appears the cycle after the drain ack.
- Reset mid-request or mid-DRAIN: all state returns to reset values. The abandoned memory transaction is not tracked.

## Test plan
- Reset, ack always 1, no stall: `imem_addr` = 0, 4, 8…; `ir` shows words in order one cycle later with `pc_ir` = 0, 4, 8; `ir_valid`=1 continuously.
- Stall held 3 cycles while ack=1: `ir`/`pc_ir` frozen; exactly one extra word buffered; `imem_req`=0 afterwards; on release, the buffered word appears next with no gap or duplicate.
- Ack latency 3 cycles: `imem_req`/`imem_addr` stable until ack; `ir_valid` pulses once per 3 cycles.
- Redirect to 0x100 while a request is outstanding (ack delayed 2 cycles): stale data discarded; `ir_valid`=0 meanwhile; next request at 0x100; first valid `pc_ir`=0x100.
- Redirect coincident with ack and with a full buffer under stall: both buffered and arriving words dropped; next request at redirect target with no DRAIN.
- `fetch_pc` at 0xFFFF_FFFC with ack: next request at 0x0000_0000. Redirect to 0x103: request at 0x100.
